// File: rtl/fir_ctrl_pkg.sv
// Shared types and default widths for the FIR sequencing controller.
package fir_ctrl_pkg;

  localparam int FIR_DATA_W   = 18;
  localparam int FIR_COEFF_W  = 18;
  localparam int FIR_RESULT_W = 38;

  // Controller phases: normal streaming, pipeline drain, bank swap, delay-line flush.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2,
    ST_FLUSH = 2'd3
  } fir_state_e;

  // Index of one of the four unique coefficients.
  typedef logic [1:0] coeff_idx_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fir_valid_tracker.sv
// Tag shift register that follows samples through the datapath pipeline.
// It advances only on enabled cycles, so a tag leaves on the same enabled
// cycle that its sample's result is presented by the datapath.
module fir_valid_tracker #(
  parameter int LATENCY = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic fir_ena,
  input  logic tag_in,
  output logic valid_out
);

  logic [LATENCY-1:0] tag_q;
  logic [LATENCY-1:0] tag_d;
  logic [LATENCY-1:0] tag_shift;

  generate
    if (LATENCY == 1) begin : g_single
      assign tag_shift = tag_in;
    end else begin : g_multi
      assign tag_shift = {tag_q[LATENCY-2:0], tag_in};
    end
  endgenerate

  // Shift tags only when the datapath advances.
  always_comb begin
    tag_d = tag_q;
    if (fir_ena) begin
      tag_d = tag_shift;
    end else begin
      tag_d = tag_q;
    end
  end

  // Tag storage; reset discards all in-flight tags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign valid_out = fir_ena & tag_q[LATENCY-1];

endmodule

// File: rtl/fir_ctrl.sv
// Sequencing controller for the 8-tap symmetric FIR datapath: sample
// handshake, datapath enable, result tagging and a double-buffered
// coefficient bank reloaded via drain -> swap -> flush.
module fir_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int DATA_W   = FIR_DATA_W,
  parameter int COEFF_W  = FIR_COEFF_W,
  parameter int RESULT_W = FIR_RESULT_W,
  parameter int NTAPS    = 8,
  parameter int LATENCY  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  output logic [DATA_W-1:0]   fir_data,
  output logic                fir_ena,
  input  logic [RESULT_W-1:0] fir_result,
  output logic                m_valid,
  output logic [RESULT_W-1:0] m_data,
  input  logic                coeff_wr,
  input  logic [1:0]          coeff_addr,
  input  logic [COEFF_W-1:0]  coeff_data,
  input  logic                coeff_commit,
  output logic                coeff_busy,
  output logic [COEFF_W-1:0]  coeff_0,
  output logic [COEFF_W-1:0]  coeff_1,
  output logic [COEFF_W-1:0]  coeff_2,
  output logic [COEFF_W-1:0]  coeff_3
);

  // Phase counter counts down from LATENCY-1 (drain) or NTAPS-1 (flush).
  localparam int PH_MAX = max_int(LATENCY, NTAPS);
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] DRAIN_LAST = PH_W'(LATENCY - 1);
  localparam logic [PH_W-1:0] FLUSH_LAST = PH_W'(NTAPS - 1);
  localparam logic [PH_W-1:0] PH_ZERO    = PH_W'(0);
  localparam logic [PH_W-1:0] PH_ONE     = PH_W'(1);

  fir_state_e               state_q, state_d;
  logic [PH_W-1:0]          phase_q, phase_d;
  logic [3:0][COEFF_W-1:0]  active_q, active_d;
  logic [3:0][COEFF_W-1:0]  shadow_q, shadow_d;
  coeff_idx_t               wr_idx;
  logic                     tag_in;

  assign wr_idx = coeff_addr;

  // State and phase registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      phase_q <= PH_ZERO;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Next-state logic: commit starts the reload; each phase runs a fixed count.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      ST_RUN: begin
        if (coeff_commit) begin
          state_d = ST_DRAIN;
          phase_d = DRAIN_LAST;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (phase_q == PH_ZERO) begin
          state_d = ST_SWAP;
        end else begin
          phase_d = phase_q - PH_ONE;
        end
      end
      ST_SWAP: begin
        state_d = ST_FLUSH;
        phase_d = FLUSH_LAST;
      end
      ST_FLUSH: begin
        if (phase_q == PH_ZERO) begin
          state_d = ST_RUN;
        end else begin
          phase_d = phase_q - PH_ONE;
        end
      end
      default: begin
        state_d = ST_RUN;
        phase_d = PH_ZERO;
      end
    endcase
  end

  // Output decode: RUN forwards accepted samples, DRAIN/FLUSH push zeros.
  always_comb begin
    s_ready    = 1'b0;
    coeff_busy = 1'b1;
    fir_ena    = 1'b0;
    fir_data   = '0;
    tag_in     = 1'b0;
    case (state_q)
      ST_RUN: begin
        s_ready    = 1'b1;
        coeff_busy = 1'b0;
        if (s_valid) begin
          fir_ena  = 1'b1;
          fir_data = s_data;
          tag_in   = 1'b1;
        end else begin
          fir_ena  = 1'b0;
        end
      end
      ST_DRAIN: fir_ena = 1'b1;
      ST_SWAP:  fir_ena = 1'b0;
      ST_FLUSH: fir_ena = 1'b1;
      default:  fir_ena = 1'b0;
    endcase
  end

  // Shadow writes are always taken; the active bank loads only in SWAP, so a
  // write landing in the SWAP cycle waits for the next commit.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (coeff_wr) begin
      shadow_d[wr_idx] = coeff_data;
    end else begin
      shadow_d = shadow_q;
    end
    if (state_q == ST_SWAP) begin
      active_d = shadow_q;
    end else begin
      active_d = active_q;
    end
  end

  // Coefficient bank registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  fir_valid_tracker #(
    .LATENCY (LATENCY)
  ) u_tracker (
    .clock     (clock),
    .reset     (reset),
    .fir_ena   (fir_ena),
    .tag_in    (tag_in),
    .valid_out (m_valid)
  );

  assign m_data  = fir_result;
  assign coeff_0 = active_q[0];
  assign coeff_1 = active_q[1];
  assign coeff_2 = active_q[2];
  assign coeff_3 = active_q[3];

endmodule

// File: tb/tb_fir_ctrl.sv
// Self-checking bench for fir_ctrl with a behavioural FIR datapath and a
// result scoreboard fed from an independent reference of the sample history.
module tb_fir_ctrl;

  localparam int DW  = 18;
  localparam int CW  = 18;
  localparam int RW  = 38;
  localparam int NT  = 8;
  localparam int LAT = 4;
  localparam int BUSY_CYC = LAT + 1 + NT;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic [DW-1:0] fir_data;
  logic          fir_ena;
  logic [RW-1:0] fir_result;
  logic          m_valid;
  logic [RW-1:0] m_data;
  logic          coeff_wr = 1'b0;
  logic [1:0]    coeff_addr = 2'd0;
  logic [CW-1:0] coeff_data = '0;
  logic          coeff_commit = 1'b0;
  logic          coeff_busy;
  logic [CW-1:0] coeff_0, coeff_1, coeff_2, coeff_3;

  always #5 clock = ~clock;

  fir_ctrl #(.DATA_W(DW), .COEFF_W(CW), .RESULT_W(RW), .NTAPS(NT), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .fir_data(fir_data), .fir_ena(fir_ena), .fir_result(fir_result), .m_valid(m_valid),
    .m_data(m_data), .coeff_wr(coeff_wr), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
    .coeff_commit(coeff_commit), .coeff_busy(coeff_busy), .coeff_0(coeff_0),
    .coeff_1(coeff_1), .coeff_2(coeff_2), .coeff_3(coeff_3)
  );

  int checks = 0;
  int errors = 0;
  int cyc;

  // Symmetric 8-tap sum: taps 4..7 mirror coefficients 3..0.
  function automatic logic [RW-1:0] fir_sum(input logic [NT-1:0][DW-1:0] x,
                                            input logic [3:0][CW-1:0] c);
    longint acc = 0;
    for (int k = 0; k < NT; k++) begin
      acc += longint'(c[(k < 4) ? k : (NT - 1 - k)]) * longint'(x[k]);
    end
    return acc[RW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural datapath: delay line plus LAT pipeline stages, all gated by fir_ena.
  logic [NT-1:0][DW-1:0]  dp_x;
  logic [LAT-1:0][RW-1:0] dp_pipe;
  logic [3:0][CW-1:0]     dut_c;
  assign dut_c      = {coeff_3, coeff_2, coeff_1, coeff_0};
  assign fir_result = dp_pipe[LAT-1];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      dp_x    <= '0;
      dp_pipe <= '0;
    end else if (fir_ena) begin
      dp_x    <= {dp_x[NT-2:0], fir_data};
      dp_pipe <= {dp_pipe[LAT-2:0], fir_sum({dp_x[NT-2:0], fir_data}, dut_c)};
    end
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Reference state and scoreboard.
  logic [NT-1:0][DW-1:0] g_x   = '0;
  logic [3:0][CW-1:0]    g_act = '0;
  logic [3:0][CW-1:0]    g_shd = '0;
  int                    busy_left = 0;
  logic [RW-1:0]         exp_q[$];
  int                    mv_cyc[$];
  logic [RW-1:0]         mv_data[$];

  // Output monitor: every m_valid must be on an enabled cycle and match the next expected result.
  always @(negedge clock) begin
    if (reset && m_valid) begin
      mv_cyc.push_back(cyc);
      mv_data.push_back(m_data);
      chk("m_valid_on_ena", 64'(fir_ena), 64'(1));
      chk("result_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) chk("m_data", 64'(m_data), 64'(exp_q.pop_front()));
    end
  end

  // One clock cycle of stimulus with per-cycle control checks and reference update.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic cm,
                      input logic wr, input logic [1:0] wa, input logic [CW-1:0] wd,
                      output logic acc);
    logic exp_ena;
    s_valid = v; s_data = d; coeff_commit = cm;
    coeff_wr = wr; coeff_addr = wa; coeff_data = wd;
    @(negedge clock);
    acc     = v && (busy_left == 0);
    exp_ena = (busy_left == 0) ? v : (busy_left != NT + 1);
    chk("s_ready", 64'(s_ready), 64'(busy_left == 0));
    chk("coeff_busy", 64'(coeff_busy), 64'(busy_left != 0));
    chk("fir_ena", 64'(fir_ena), 64'(exp_ena));
    chk("fir_data", 64'(fir_data), 64'(acc ? d : {DW{1'b0}}));
    chk("coeff_lo", 64'({coeff_1, coeff_0}), 64'({g_act[1], g_act[0]}));
    chk("coeff_hi", 64'({coeff_3, coeff_2}), 64'({g_act[3], g_act[2]}));
    if (acc) begin
      g_x = {g_x[NT-2:0], d};
      exp_q.push_back(fir_sum(g_x, g_act));
    end
    if (busy_left == NT + 1) begin
      g_act = g_shd;
      g_x   = '0;
    end
    if (wr) g_shd[wa] = wd;
    if (busy_left > 0) busy_left--;
    else if (cm)       busy_left = BUSY_CYC;
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 2'd0, '0, a);
  endtask

  task automatic wr_coeff(input logic [1:0] wa, input logic [CW-1:0] wd);
    logic a;
    step(1'b0, '0, 1'b0, 1'b1, wa, wd, a);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'(1));
    chk({tag, "_fir_ena"}, 64'(fir_ena), 64'(0));
    chk({tag, "_fir_data"}, 64'(fir_data), 64'(0));
    chk({tag, "_m_valid"}, 64'(m_valid), 64'(0));
    chk({tag, "_busy"}, 64'(coeff_busy), 64'(0));
    chk({tag, "_coeffs"}, 64'({coeff_3, coeff_2, coeff_1} | {54'd0, coeff_0}), 64'(0));
  endtask

  initial begin
    logic a;
    int   lowcnt, idx, ccyc, n_drain, n_flush, nmv;
    int   exp_imp[8] = '{1, 2, 3, 4, 4, 3, 2, 1};

    // Reset values while reset is held.
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;

    // 1: three samples back-to-back, commit on the third; zero coefficients.
    step(1'b1, 18'd1, 1'b0, 1'b0, 2'd0, '0, a);
    step(1'b1, 18'd2, 1'b0, 1'b0, 2'd0, '0, a);
    step(1'b1, 18'd3, 1'b1, 1'b0, 2'd0, '0, a);
    idle(BUSY_CYC + 2);
    chk("t1_mvalid_count", 64'(mv_cyc.size()), 64'(3));
    for (int i = 0; i < mv_cyc.size() && i < 3; i++) begin
      chk("t1_mvalid_cycle", 64'(mv_cyc[i]), 64'(4 + i));
      chk("t1_mdata_zero", 64'(mv_data[i]), 64'(0));
    end

    // 2: load 1,2,3,4, commit with no traffic, then an impulse.
    wr_coeff(2'd0, 18'd1); wr_coeff(2'd1, 18'd2);
    wr_coeff(2'd2, 18'd3); wr_coeff(2'd3, 18'd4);
    step(1'b0, '0, 1'b1, 1'b0, 2'd0, '0, a);
    lowcnt = 0;
    for (int i = 0; i < BUSY_CYC + 3; i++) begin
      if (!s_ready) lowcnt++;
      idle(1);
    end
    chk("t2_ready_low_cycles", 64'(lowcnt), 64'(BUSY_CYC));
    chk("t2_coeff_0", 64'(coeff_0), 64'(1));
    chk("t2_coeff_3", 64'(coeff_3), 64'(4));
    mv_data.delete();
    step(1'b1, 18'd1, 1'b0, 1'b0, 2'd0, '0, a);
    for (int i = 0; i < 11; i++) step(1'b1, 18'd0, 1'b0, 1'b0, 2'd0, '0, a);
    chk("t2_impulse_count", 64'(mv_data.size()), 64'(8));
    for (int i = 0; i < 8 && i < mv_data.size(); i++)
      chk("t2_impulse_tap", 64'(mv_data[i]), 64'(exp_imp[i]));

    // 3: ten samples, commit on the fifth acceptance with a new bank staged.
    wr_coeff(2'd0, 18'd5); wr_coeff(2'd1, 18'd6);
    wr_coeff(2'd2, 18'd7); wr_coeff(2'd3, 18'd8);
    mv_cyc.delete();
    for (int i = 1; i <= 4; i++) step(1'b1, DW'(i * 3), 1'b0, 1'b0, 2'd0, '0, a);
    ccyc = cyc;
    step(1'b1, 18'd15, 1'b1, 1'b0, 2'd0, '0, a);
    idx = 6;
    for (int n = 0; n < 60 && idx <= 10; n++) begin
      step(1'b1, DW'(idx * 3), 1'b0, 1'b0, 2'd0, '0, a);
      if (a) idx++;
    end
    chk("t3_all_accepted", 64'(idx), 64'(11));
    n_drain = 0; n_flush = 0;
    foreach (mv_cyc[i]) begin
      if (mv_cyc[i] >= ccyc && mv_cyc[i] <= ccyc + LAT) n_drain++;
      if (mv_cyc[i] > ccyc + LAT && mv_cyc[i] <= ccyc + BUSY_CYC) n_flush++;
    end
    chk("t3_old_bank_results", 64'(n_drain), 64'(5));
    chk("t3_none_in_flush", 64'(n_flush), 64'(0));

    // 4: stalled stream 1,0,0,1.
    step(1'b1, 18'd11, 1'b0, 1'b0, 2'd0, '0, a);
    step(1'b0, 18'd77, 1'b0, 1'b0, 2'd0, '0, a);
    step(1'b0, 18'd77, 1'b0, 1'b0, 2'd0, '0, a);
    step(1'b1, 18'd12, 1'b0, 1'b0, 2'd0, '0, a);

    // 5: commit, a second commit while busy, and a write in the SWAP cycle.
    step(1'b0, '0, 1'b1, 1'b0, 2'd0, '0, a);
    for (int i = 0; i < BUSY_CYC + 2; i++)
      step(1'b0, '0, (i == 1), (busy_left == NT + 1), 2'd0, 18'd99, a);
    chk("t5_late_write_held", 64'(coeff_0), 64'(5));
    step(1'b0, '0, 1'b1, 1'b0, 2'd0, '0, a);
    idle(BUSY_CYC + 1);
    chk("t5_late_write_applied", 64'(coeff_0), 64'(99));

    // 6: reset in the middle of a drain.
    step(1'b1, 18'd5, 1'b0, 1'b0, 2'd0, '0, a);
    step(1'b1, 18'd6, 1'b1, 1'b0, 2'd0, '0, a);
    idle(2);
    s_valid = 1'b0; coeff_commit = 1'b0; coeff_wr = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    g_x = '0; g_act = '0; g_shd = '0; busy_left = 0;
    @(posedge clock); #1;
    reset = 1'b1;
    nmv = mv_cyc.size();
    step(1'b1, 18'd7, 1'b0, 1'b0, 2'd0, '0, a);
    step(1'b1, 18'd8, 1'b1, 1'b0, 2'd0, '0, a);
    idle(BUSY_CYC + 1);
    chk("t6_mvalid_after_reset", 64'(mv_cyc.size() - nmv), 64'(2));

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_ctrl.md
# fir_ctrl

Sequencing controller for the 8-tap symmetric FIR datapath, i.e. the two cascaded multiply-add stages plus the final adder. It admits input samples over a valid/ready handshake, drives the datapath's clock enable and data input, and tags results so each output is flagged valid exactly once. It also owns the 4 unique coefficients as a double-buffered bank, with safe runtime reload: drain, swap, flush, then resume. It sits between the sample source and the FIR datapath; the top level mirrors `coeff_0..3` onto taps 7..4.

## Interface
- `DATA_W`, 18: sample width
- `COEFF_W`, 18: coefficient width
- `RESULT_W`, 38: FIR result width
- `NTAPS`, 8: delay-line length; zeros fed after a swap
- `LATENCY`, 4: enabled cycles from sample on `fir_data` to its result on `fir_result`; must be ≥1
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `s_valid`  in  1  input sample valid
- `s_ready`  out  1  controller accepts sample
- `s_data`  in  DATA_W  input sample
- `fir_data`  out  DATA_W  to datapath `data_in`
- `fir_ena`  out  1  to datapath `clk_ena`
- `fir_result`  in  RESULT_W  from datapath
- `m_valid`  out  1  result valid, single-cycle pulse
- `m_data`  out  RESULT_W  result; equals `fir_result` combinationally
- `coeff_wr`  in  1  write shadow coefficient
- `coeff_addr`  in  2  shadow index 0..3
- `coeff_data`  in  COEFF_W  shadow write data
- `coeff_commit`  in  1  pulse: request shadow→active swap
- `coeff_busy`  out  1  reload sequence in progress
- `coeff_0..coeff_3`  out  COEFF_W each  active coefficients

## Operation
- Datapath contract: every datapath pipeline register advances only when `fir_ena`=1.
- States: RUN (reset state), DRAIN, SWAP, FLUSH. `s_ready` = (state==RUN).
- RUN:
  - Accept when `s_valid & s_ready`: `fir_ena`=1, `fir_data`=`s_data`, tag 1 enters the tracker.
  - Otherwise `fir_ena`=0 and `fir_data`=0.
  - On `coeff_commit`, go to DRAIN and raise `coeff_busy`. A sample offered in that same cycle is still accepted.
- DRAIN: LATENCY cycles of `fir_ena`=1, `fir_data`=0, tag 0. Pending samples emerge computed with the old coefficients. Then go to SWAP.
- SWAP: one cycle with `fir_ena`=0. Active bank ← shadow at the cycle end. Then go to FLUSH.
- FLUSH: NTAPS cycles of `fir_ena`=1, `fir_data`=0, tag 0. Clears the delay line. Then go to RUN and drop `coeff_busy`.
- Tracker: a LATENCY-bit tag shift register that shifts only on `fir_ena`. `m_valid` = `fir_ena` & last tag bit. The tag inserted with a sample therefore reaches the output on that sample's LATENCY-th subsequent enabled cycle.
- Shadow writes:
  - Allowed in any state.
  - A write in the same cycle as a commit, or before the SWAP cycle, is included in the swap.
  - A write in the SWAP cycle or later is held for the next commit.
- `coeff_commit` while `coeff_busy`=1 is ignored.
- Coefficients are loaded as raw bit patterns; the controller does no arithmetic on them.

## Timing
- Reset values:
  - state RUN; `s_ready`=1; `fir_ena`=0; `fir_data`=0; `m_valid`=0; `coeff_busy`=0.
  - Active and shadow coefficients all 0; all tags 0.
- Reset asserted mid-operation:
  - Pending tags are discarded, so no `m_valid` is produced for in-flight samples.
  - The sequence is aborted and active coefficients return to 0.
- Streaming: one sample per cycle with no bubbles. A sample accepted at cycle t, with uninterrupted acceptance thereafter, gives `m_valid` at t+LATENCY.
- Stalls: when `s_valid`=0 nothing advances, and the result is held until the next enabled cycle.
- Reload blocking: `s_ready` is low for exactly LATENCY+1+NTAPS cycles, starting the cycle after commit.
- `coeff_0..3` change only at the SWAP cycle edge.

## Structure
- Package `fir_ctrl_pkg` holds:
  - the state enum (RUN/DRAIN/SWAP/FLUSH);
  - default width constants (DATA_W, COEFF_W, RESULT_W);
  - the coefficient index type (2-bit).
- One sub-module, `fir_valid_tracker`: parameterised by LATENCY; inputs `fir_ena` and tag-in; output the valid pulse.
- The phase counter is sized for max(LATENCY, NTAPS).

## Test plan
- Reset then stream samples 1,2,3 back-to-back from cycle 0 → `m_valid` at cycles 4,5,6. With coefficients all 0, `m_data`=0; no other `m_valid` pulses.
- Write shadow 0..3 = 1,2,3,4, commit with no traffic:
  - `s_ready` low for 13 cycles; `coeff_0..3` = 1,2,3,4 after the SWAP edge.
  - An impulse of 1 then yields `m_data` = 1,2,3,4,4,3,2,1 on consecutive `m_valid`s.
- Stream 10 samples with commit at the 5th acceptance:
  - 5 `m_valid`s with old-coefficient results, none during FLUSH.
  - After resume, the first result uses the new bank on a zeroed delay line.
- `s_valid` toggling 1,0,0,1 → `fir_ena` mirrors acceptance; `m_valid` appears only on enabled cycles, one per sample.
- Commit while busy, and a `coeff_wr` during the SWAP cycle → second commit ignored; the late write lands in `coeff_*` only after the next commit.
- Assert `reset` mid-DRAIN → outputs at reset values immediately; no `m_valid` for the drained samples.
